// File: rtl/divider_sequencer.sv
// divider_sequencer
//   Programmable clock-enable sequencer. Divides CLK into a one-cycle TICK
//   at every half-period boundary and a square-wave CLK_OUT, with start/stop
//   control, optional burst length and a valid/ready configuration port.
//
// Ports:
//   CLK        system clock, all logic on the rising edge
//   RST        asynchronous active-high reset
//   CFG_VALID  configuration offer
//   CFG_READY  configuration can be accepted (low while a pending config waits)
//   CFG_DIV    half-period length in CLK cycles (values below 2 stored as 2)
//   CFG_BURST  half-periods per run, 0 = free-run
//   START      level-sampled start request (ignored while running)
//   STOP       level-sampled stop request (wins over START)
//   TICK       one-cycle pulse at each half-period boundary
//   CLK_OUT    divided square wave
//   BUSY       high while running
//   DONE       one-cycle pulse when a burst completes
//   TICK_COUNT free-running count of TICK pulses, present only when the
//              macro DIVSEQ_TICK_COUNT_EN is defined
module divider_sequencer #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 25000,
    parameter int BURST_W     = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CFG_VALID,
    output logic               CFG_READY,
    input  logic [CNT_W-1:0]   CFG_DIV,
    input  logic [BURST_W-1:0] CFG_BURST,
    input  logic               START,
    input  logic               STOP,
    output logic               TICK,
    output logic               CLK_OUT,
    output logic               BUSY,
    output logic               DONE
`ifdef DIVSEQ_TICK_COUNT_EN
    ,
    output logic [15:0]        TICK_COUNT
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEFAULT_DIV_C = CNT_W'(DEFAULT_DIV);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   div_reg;
    logic [CNT_W-1:0]   pend_div_reg;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [BURST_W-1:0] burst_reg;
    logic [BURST_W-1:0] pend_burst_reg;
    logic               tick_reg;
    logic               clk_out_reg;
    logic               done_reg;
    // ready_reg low <=> a pending configuration is waiting for a boundary
    logic               ready_reg;
`ifdef DIVSEQ_TICK_COUNT_EN
    logic [15:0]        tick_count_reg;
`endif

    logic               xfer;
    logic [CNT_W-1:0]   cfg_div_clamped;
    logic               at_boundary;
    logic [BURST_W-1:0] burst_cnt_inc;
    logic               burst_done;

    assign xfer            = CFG_VALID & ready_reg;
    assign cfg_div_clamped = (CFG_DIV < CNT_W'(2)) ? CNT_W'(2) : CFG_DIV;
    assign at_boundary     = (cnt_reg == div_reg - CNT_W'(1));
    assign burst_cnt_inc   = burst_cnt_reg + BURST_W'(1);
    // Completion is judged against the burst length in force before any
    // pending config is applied on the same edge.
    assign burst_done      = (burst_reg != '0) && (burst_cnt_inc == burst_reg);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            div_reg        <= DEFAULT_DIV_C;
            pend_div_reg   <= DEFAULT_DIV_C;
            burst_cnt_reg  <= '0;
            burst_reg      <= '0;
            pend_burst_reg <= '0;
            tick_reg       <= 1'b0;
            clk_out_reg    <= 1'b0;
            done_reg       <= 1'b0;
            ready_reg      <= 1'b1;
`ifdef DIVSEQ_TICK_COUNT_EN
            tick_count_reg <= '0;
`endif
        end else begin
            tick_reg <= 1'b0;
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                cnt_reg     <= '0;
                clk_out_reg <= 1'b0;
                if (xfer) begin
                    div_reg   <= cfg_div_clamped;
                    burst_reg <= CFG_BURST;
                end
                if (START && !STOP) begin
                    state_reg     <= RUN;
                    burst_cnt_reg <= '0;
                end
            end else if (STOP) begin
                // Leaving RUN: there is no further boundary to apply a
                // pending config at, so any outstanding config is applied
                // now rather than leaving CFG_READY stuck low in IDLE.
                state_reg   <= IDLE;
                cnt_reg     <= '0;
                clk_out_reg <= 1'b0;
                ready_reg   <= 1'b1;
                if (xfer) begin
                    div_reg   <= cfg_div_clamped;
                    burst_reg <= CFG_BURST;
                end else if (!ready_reg) begin
                    div_reg   <= pend_div_reg;
                    burst_reg <= pend_burst_reg;
                end
            end else if (at_boundary) begin
                cnt_reg     <= '0;
                tick_reg    <= 1'b1;
                clk_out_reg <= ~clk_out_reg;
`ifdef DIVSEQ_TICK_COUNT_EN
                tick_count_reg <= tick_count_reg + 16'd1;
`endif
                if (!ready_reg) begin
                    div_reg       <= pend_div_reg;
                    burst_reg     <= pend_burst_reg;
                    burst_cnt_reg <= '0;
                    ready_reg     <= 1'b1;
                end else begin
                    burst_cnt_reg <= burst_cnt_inc;
                    if (xfer) begin
                        if (burst_done) begin
                            // Run ends on this edge: apply directly.
                            div_reg   <= cfg_div_clamped;
                            burst_reg <= CFG_BURST;
                        end else begin
                            pend_div_reg   <= cfg_div_clamped;
                            pend_burst_reg <= CFG_BURST;
                            ready_reg      <= 1'b0;
                        end
                    end
                end
                if (burst_done) begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (xfer) begin
                    pend_div_reg   <= cfg_div_clamped;
                    pend_burst_reg <= CFG_BURST;
                    ready_reg      <= 1'b0;
                end
            end
        end
    end

    assign TICK      = tick_reg;
    assign CLK_OUT   = clk_out_reg;
    assign DONE      = done_reg;
    assign CFG_READY = ready_reg;
    assign BUSY      = (state_reg == RUN);
`ifdef DIVSEQ_TICK_COUNT_EN
    assign TICK_COUNT = tick_count_reg;
`endif

endmodule
